// File: rtl/starfish_arb_pkg.sv
// Shared types for the Starfish memory arbiter: FSM encoding, access size
// and the request record latched onto the external bus.
package starfish_arb_pkg;

    // Arbiter sequencing states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUS_I = 2'd1,
        BUS_D = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    // Access size as carried on d_size / bus_size
    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } mem_size_e;

    // Storage widths of the latched request. Module ADDR_W/DATA_W must not
    // exceed these; narrower buses are zero-extended into the record.
    localparam int ARB_ADDR_W = 32;
    localparam int ARB_DATA_W = 32;

    // Wait counter covers TIMEOUT up to 255, starvation counter up to 15
    localparam int WAIT_W   = 8;
    localparam int STARVE_W = 4;

    // Request record presented on the bus_* outputs
    typedef struct packed {
        logic                  we;
        logic [ARB_ADDR_W-1:0] addr;
        logic [ARB_DATA_W-1:0] wdata;
        mem_size_e             size;
        logic                  sign;
    } bus_req_t;

endpackage

// File: rtl/arb_wait_timer.sv
// Bus wait counter: cleared on a grant, counts while a transaction is open
// and saturates at TIMEOUT, flagging expiry through a registered compare.
module arb_wait_timer
    import starfish_arb_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT);

    logic [WAIT_W-1:0] count_reg;

    // Clear on grant, then count up while waiting, holding at the limit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (en && (count_reg != WAIT_LIMIT)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign expired = (count_reg == WAIT_LIMIT);

endmodule

// File: rtl/starfish_mem_arbiter.sv
// Two-port arbiter that shares one variable-latency memory bus between the
// instruction-fetch port and the data port, with starvation protection for
// fetch and a bounded wait that turns a silent bus into an error completion.
module starfish_mem_arbiter
    import starfish_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int TIMEOUT      = 15,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    // fetch port
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    // data port
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [1:0]        d_size,
    input  logic              d_sign,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    // external bus
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic [1:0]        bus_size,
    output logic              bus_sign,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              err
);

    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    arb_state_e          state_reg;
    bus_req_t            bus_cmd_reg;
    bus_req_t            grant_cmd;
    logic                bus_req_reg;
    logic                if_valid_reg;
    logic                d_valid_reg;
    logic                err_reg;
    logic [DATA_W-1:0]   if_rdata_reg;
    logic [DATA_W-1:0]   d_rdata_reg;
    logic [STARVE_W-1:0] starve_cnt_reg;

    logic grant_i;
    logic grant_d;
    logic in_bus;
    logic wait_expired;
    logic bus_done;
    logic timed_out;

    assign in_bus    = (state_reg == BUS_I) || (state_reg == BUS_D);
    // An ack arriving together with expiry still counts as a good completion
    assign bus_done  = in_bus && (bus_ack || wait_expired);
    assign timed_out = !bus_ack && wait_expired;

    // Arbitrate in IDLE only: data first unless fetch has been starved
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (state_reg == IDLE) begin
            if (d_req && !(if_req && (starve_cnt_reg == STARVE_MAX))) begin
                grant_d = 1'b1;
            end else if (if_req) begin
                grant_i = 1'b1;
            end
        end
    end

    // Assemble the bus record for whichever port wins; fetch is a word read
    always_comb begin
        grant_cmd = '0;
        if (grant_d) begin
            grant_cmd.we    = d_we;
            grant_cmd.addr  = ARB_ADDR_W'(d_addr);
            grant_cmd.wdata = ARB_DATA_W'(d_wdata);
            grant_cmd.size  = mem_size_e'(d_size);
            grant_cmd.sign  = d_sign;
        end else begin
            grant_cmd.addr  = ARB_ADDR_W'(if_addr);
            grant_cmd.size  = WORD;
        end
    end

    arb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (grant_i || grant_d),
        .en      (in_bus),
        .expired (wait_expired)
    );

    // Main sequencer: grant, wait for ack or timeout, then one response cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            bus_cmd_reg  <= '0;
            bus_req_reg  <= 1'b0;
            if_valid_reg <= 1'b0;
            d_valid_reg  <= 1'b0;
            err_reg      <= 1'b0;
            if_rdata_reg <= '0;
            d_rdata_reg  <= '0;
        end else begin
            if_valid_reg <= 1'b0;
            d_valid_reg  <= 1'b0;
            err_reg      <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (grant_d || grant_i) begin
                        bus_cmd_reg <= grant_cmd;
                        bus_req_reg <= 1'b1;
                        state_reg   <= grant_d ? BUS_D : BUS_I;
                    end
                end
                BUS_I, BUS_D: begin
                    if (bus_done) begin
                        bus_req_reg <= 1'b0;
                        err_reg     <= timed_out;
                        state_reg   <= RESP;
                        if (state_reg == BUS_I) begin
                            if_valid_reg <= 1'b1;
                            if_rdata_reg <= bus_ack ? bus_rdata : '0;
                        end else begin
                            d_valid_reg <= 1'b1;
                            d_rdata_reg <= (bus_ack && !bus_cmd_reg.we) ? bus_rdata : '0;
                        end
                    end
                end
                RESP: begin
                    // The completing requester still holds req this cycle
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Count data grants that overtake a waiting fetch, saturating at the limit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt_reg <= '0;
        end else if (!if_req || grant_i) begin
            starve_cnt_reg <= '0;
        end else if (grant_d && (starve_cnt_reg != STARVE_MAX)) begin
            starve_cnt_reg <= starve_cnt_reg + 1'b1;
        end
    end

    assign if_rdata  = if_rdata_reg;
    assign if_valid  = if_valid_reg;
    assign d_rdata   = d_rdata_reg;
    assign d_valid   = d_valid_reg;
    assign err       = err_reg;
    assign bus_req   = bus_req_reg;
    assign bus_we    = bus_cmd_reg.we;
    assign bus_addr  = bus_cmd_reg.addr[ADDR_W-1:0];
    assign bus_wdata = bus_cmd_reg.wdata[DATA_W-1:0];
    assign bus_size  = bus_cmd_reg.size;
    assign bus_sign  = bus_cmd_reg.sign;

endmodule

// File: tb/tb_starfish_mem_arbiter.sv
// Scoreboard bench for starfish_mem_arbiter: expected grants and responses
// are queued as requests are issued and consumed by a monitor on the outputs.
module tb_starfish_mem_arbiter;
    import starfish_arb_pkg::*;

    localparam int ADDR_W       = 32;
    localparam int DATA_W       = 32;
    localparam int TIMEOUT      = 15;
    localparam int STARVE_LIMIT = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_valid;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [1:0]        d_size;
    logic              d_sign;
    logic [DATA_W-1:0] d_rdata;
    logic              d_valid;
    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic [1:0]        bus_size;
    logic              bus_sign;
    logic              bus_ack;
    logic [DATA_W-1:0] bus_rdata;
    logic              err;

    always #5 clk = ~clk;

    starfish_mem_arbiter #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .TIMEOUT      (TIMEOUT),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_valid  (if_valid),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_size    (d_size),
        .d_sign    (d_sign),
        .d_rdata   (d_rdata),
        .d_valid   (d_valid),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_size  (bus_size),
        .bus_sign  (bus_sign),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata),
        .err       (err)
    );

    typedef struct {
        int          port;   // 0 = fetch, 1 = data
        logic [31:0] addr;
        logic        we;
        logic [1:0]  size;
        logic        sign;
        logic [31:0] wdata;
    } grant_t;

    typedef struct {
        int          port;
        logic [31:0] data;
        logic        err;
    } resp_t;

    grant_t grant_q[$];
    resp_t  resp_q[$];

    int vec_cnt  = 0;
    int miss_cnt = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Memory contents seen by the bus model
    function automatic logic [31:0] bus_word(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 32'h0000_0013;
            32'h0000_2000: return 32'hDEAD_BEEF;
            default:       return (a * 32'h0000_9E37) ^ 32'h5A5A_0000;
        endcase
    endfunction

    task automatic push_txn(input int port, input logic [31:0] addr, input logic we,
                            input logic [1:0] size, input logic sign, input logic [31:0] wdata,
                            input logic [31:0] data, input logic e);
        grant_t g;
        resp_t  r;
        g.port = port; g.addr = addr; g.we = we; g.size = size; g.sign = sign; g.wdata = wdata;
        r.port = port; r.data = data; r.err = e;
        grant_q.push_back(g);
        resp_q.push_back(r);
    endtask

    // Bus responder: acks ack_delay cycles into a transaction (-1 = never)
    int ack_delay = 0;
    bit stray_ack = 1'b0;
    int wait_cnt  = 0;
    initial begin : bus_model
        bus_ack   = 1'b0;
        bus_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            bus_ack   = 1'b0;
            bus_rdata = '0;
            if (stray_ack) begin
                bus_ack   = 1'b1;
                bus_rdata = 32'hBADB_AD00;
            end else if (bus_req === 1'b1) begin
                if (wait_cnt == ack_delay) begin
                    bus_ack   = 1'b1;
                    bus_rdata = bus_word(bus_addr);
                end
                wait_cnt++;
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Monitor: check grants on bus_req rise and responses on valid pulses
    logic   prev_bus_req = 1'b0;
    int     cur_len  = 0;
    int     last_len = 0;
    grant_t mon_g;
    resp_t  mon_r;
    always @(negedge clk) begin
        if (bus_req === 1'b1 && !prev_bus_req) begin
            if (grant_q.size() == 0) begin
                check_val("grant_unexpected", bus_req, 0);
            end else begin
                mon_g = grant_q.pop_front();
                check_val("grant_addr", bus_addr, mon_g.addr);
                check_val("grant_we", bus_we, mon_g.we);
                if (mon_g.port == 1) begin
                    check_val("grant_size", bus_size, mon_g.size);
                    check_val("grant_sign", bus_sign, mon_g.sign);
                    if (mon_g.we) check_val("grant_wdata", bus_wdata, mon_g.wdata);
                end
            end
        end
        if (if_valid === 1'b1 || d_valid === 1'b1) begin
            if (resp_q.size() == 0) begin
                check_val("resp_unexpected", {30'b0, d_valid, if_valid}, 0);
            end else begin
                mon_r = resp_q.pop_front();
                check_val("resp_port", {30'b0, d_valid, if_valid}, (mon_r.port == 1) ? 2 : 1);
                check_val("resp_data", (mon_r.port == 1) ? d_rdata : if_rdata, mon_r.data);
                check_val("resp_err", err, mon_r.err);
                $display("txn %s rdata=0x%08h err=%0b", (mon_r.port == 1) ? "data " : "fetch",
                         (mon_r.port == 1) ? d_rdata : if_rdata, err);
            end
        end else if (err !== 1'b0) begin
            check_val("err_without_valid", err, 0);
        end
        if (bus_req === 1'b1) begin
            cur_len++;
        end else if (cur_len != 0) begin
            last_len = cur_len;
            cur_len  = 0;
        end
        prev_bus_req = (bus_req === 1'b1);
    end

    task automatic do_fetch(input logic [31:0] addr, output int lat);
        if_req  = 1'b1;
        if_addr = addr;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (if_valid !== 1'b1 && lat < 100);
        check_val("fetch_complete", if_valid, 1);
        if_req = 1'b0;
    endtask

    task automatic do_data(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [1:0] size, input logic sign, output int lat);
        d_req   = 1'b1;
        d_we    = we;
        d_addr  = addr;
        d_wdata = wdata;
        d_size  = size;
        d_sign  = sign;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (d_valid !== 1'b1 && lat < 100);
        check_val("data_complete", d_valid, 1);
        d_req = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int lat;
        int lat_d;
        int lat_i;
        int lat_s;
        int lat_f;
        grant_t g;

        rst_n   = 1'b0;
        if_req  = 1'b0;
        if_addr = '0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        d_size  = 2'd0;
        d_sign  = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check_val("rst_bus_req", bus_req, 0);
        check_val("rst_if_valid", if_valid, 0);
        check_val("rst_d_valid", d_valid, 0);
        check_val("rst_err", err, 0);
        check_val("rst_bus_addr", bus_addr, 0);
        check_val("rst_if_rdata", if_rdata, 0);
        check_val("rst_d_rdata", d_rdata, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single fetch at minimum latency
        ack_delay = 0;
        push_txn(0, 32'h100, 1'b0, 2'd2, 1'b0, 32'h0, 32'h13, 1'b0);
        do_fetch(32'h100, lat);
        check_val("fetch_min_latency", lat, 2);

        // Simultaneous requests: data first, fetch at the next IDLE
        @(negedge clk);
        ack_delay = 3;
        push_txn(1, 32'h2000, 1'b0, 2'd2, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0);
        push_txn(0, 32'h104, 1'b0, 2'd2, 1'b0, 32'h0, bus_word(32'h104), 1'b0);
        fork
            do_data(1'b0, 32'h2000, 32'h0, 2'd2, 1'b0, lat_d);
            do_fetch(32'h104, lat_i);
        join
        check_val("simul_data_latency", lat_d, 5);
        check_val("simul_fetch_latency", lat_i, 11);

        // Starvation: four data grants, then the held fetch is forced
        @(negedge clk);
        ack_delay = 1;
        for (int k = 0; k < 4; k++) begin
            push_txn(1, 32'h3000 + 4 * k, 1'b0, 2'd2, 1'b0, 32'h0, bus_word(32'h3000 + 4 * k), 1'b0);
        end
        push_txn(0, 32'h400, 1'b0, 2'd2, 1'b0, 32'h0, bus_word(32'h400), 1'b0);
        push_txn(1, 32'h3010, 1'b0, 2'd2, 1'b0, 32'h0, bus_word(32'h3010), 1'b0);
        fork
            begin
                for (int k = 0; k < 5; k++) begin
                    do_data(1'b0, 32'h3000 + 4 * k, 32'h0, 2'd2, 1'b0, lat_s);
                end
            end
            begin
                do_fetch(32'h400, lat_f);
                check_val("starve_cnt_after_fetch", dut.starve_cnt_reg, 0);
            end
        join
        check_val("starve_fetch_latency", lat_f, 19);

        // Store against a dead bus: timeout error
        @(negedge clk);
        ack_delay = -1;
        push_txn(1, 32'h5000, 1'b1, 2'd2, 1'b0, 32'hCAFE_F00D, 32'h0, 1'b1);
        do_data(1'b1, 32'h5000, 32'hCAFE_F00D, 2'd2, 1'b0, lat);
        check_val("timeout_latency", lat, TIMEOUT + 2);
        @(negedge clk);
        check_val("timeout_bus_req_len", last_len, TIMEOUT + 1);

        // Ack in the same cycle as expiry: ack wins
        ack_delay = TIMEOUT;
        push_txn(1, 32'h6000, 1'b0, 2'd2, 1'b0, 32'h0, bus_word(32'h6000), 1'b0);
        do_data(1'b0, 32'h6000, 32'h0, 2'd2, 1'b0, lat);
        check_val("late_ack_latency", lat, TIMEOUT + 2);
        @(negedge clk);
        check_val("late_ack_bus_req_len", last_len, TIMEOUT + 1);

        // Byte store and signed half load: field pass-through
        ack_delay = 2;
        push_txn(1, 32'h7001, 1'b1, 2'd0, 1'b1, 32'h0000_00AB, 32'h0, 1'b0);
        do_data(1'b1, 32'h7001, 32'h0000_00AB, 2'd0, 1'b1, lat);
        check_val("byte_store_latency", lat, 4);
        @(negedge clk);
        ack_delay = 0;
        push_txn(1, 32'h7002, 1'b0, 2'd1, 1'b1, 32'h0, bus_word(32'h7002), 1'b0);
        do_data(1'b0, 32'h7002, 32'h0, 2'd1, 1'b1, lat);
        check_val("half_load_latency", lat, 2);

        // Reset during the second BUS_D wait cycle abandons the access
        @(negedge clk);
        ack_delay = -1;
        g.port = 1; g.addr = 32'h7100; g.we = 1'b0; g.size = 2'd2; g.sign = 1'b0; g.wdata = 32'h0;
        grant_q.push_back(g);
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 32'h7100;
        d_wdata = 32'h0;
        d_size  = 2'd2;
        d_sign  = 1'b0;
        @(negedge clk);
        check_val("rstmid_bus_req_wait1", bus_req, 1);
        @(negedge clk);
        rst_n = 1'b0;
        d_req = 1'b0;
        @(negedge clk);
        check_val("rstmid_bus_req", bus_req, 0);
        check_val("rstmid_d_valid", d_valid, 0);
        check_val("rstmid_err", err, 0);
        rst_n = 1'b1;
        stray_ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_val("stray_d_valid", d_valid, 0);
            check_val("stray_if_valid", if_valid, 0);
            check_val("stray_bus_req", bus_req, 0);
        end
        stray_ack = 1'b0;
        repeat (2) @(negedge clk);

        // Recovery after reset
        ack_delay = 0;
        push_txn(0, 32'h800, 1'b0, 2'd2, 1'b0, 32'h0, bus_word(32'h800), 1'b0);
        do_fetch(32'h800, lat);
        check_val("recover_fetch_latency", lat, 2);

        repeat (3) @(negedge clk);
        check_val("grant_q_drained", grant_q.size(), 0);
        check_val("resp_q_drained", resp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
